// File: rtl/hwrandom_pool.sv
// hwrandom_pool: synchronises and XORs ring-oscillator inputs, optionally Von Neumann de-biases,
// runs a repetition-count health test and packs bits into words buffered in a show-ahead FIFO.
module hwrandom_pool #(
    parameter int NUM_CHANNELS = 8,
    parameter int WORD_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int REP_LIMIT    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CHANNELS-1:0]       raw_in,
    input  logic                          debias_en,
    output logic [WORD_BITS-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          health_fail,
    input  logic                          health_clear,
    output logic [7:0]                    drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(WORD_BITS);
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [NUM_CHANNELS-1:0] sync1, sync2;
    logic [1:0]              warm;
    logic                    cbit, cbit_q, bit_vld, mode_chg, debias_q, phase, pair_a;
    logic                    emit, new_bit, word_done, pop, push, full;
    logic [RW-1:0]           rep_cnt, rep_next;
    logic [BW-1:0]           bit_cnt;
    logic [WORD_BITS-1:0]    word, word_next;
    logic [WORD_BITS-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;

    // warm tags the synchroniser contents so pre-reset samples never become bits
    assign cbit      = ^sync2;
    assign bit_vld   = warm[1];
    assign mode_chg  = debias_en != debias_q;
    assign emit      = bit_vld & ~health_fail & ~mode_chg & (debias_en ? (phase & (pair_a != cbit)) : 1'b1);
    assign new_bit   = debias_en ? pair_a : cbit;
    assign word_done = emit & (bit_cnt == BW'(WORD_BITS - 1));
    assign pop       = out_valid & out_ready;
    assign full      = fifo_level == (AW+1)'(FIFO_DEPTH);
    assign push      = word_done & (~full | pop);
    assign out_valid = fifo_level != '0;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign rep_next  = (cbit != cbit_q) ? RW'(1) : (rep_cnt == RW'(REP_LIMIT)) ? rep_cnt : rep_cnt + RW'(1);

    always_comb begin
        word_next          = word;
        word_next[bit_cnt] = new_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            warm        <= '0;
            cbit_q      <= 1'b0;
            rep_cnt     <= '0;
            health_fail <= 1'b0;
            debias_q    <= 1'b0;
            phase       <= 1'b0;
            pair_a      <= 1'b0;
            bit_cnt     <= '0;
            word        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            drop_cnt    <= '0;
        end else begin
            sync1       <= raw_in;
            sync2       <= sync1;
            warm        <= {warm[0], 1'b1};
            debias_q    <= debias_en;
            cbit_q      <= bit_vld ? cbit : cbit_q;
            rep_cnt     <= health_clear ? '0 : bit_vld ? rep_next : rep_cnt;
            health_fail <= ~health_clear & (health_fail | (bit_vld & (rep_next == RW'(REP_LIMIT))));
            phase       <= mode_chg ? 1'b0 : phase ^ bit_vld;
            pair_a      <= (bit_vld & ~phase) ? cbit : pair_a;
            bit_cnt     <= (mode_chg | health_fail | word_done) ? '0 : emit ? bit_cnt + BW'(1) : bit_cnt;
            word        <= emit ? word_next : word;
            wr_ptr      <= wr_ptr + AW'(push);
            rd_ptr      <= rd_ptr + AW'(pop);
            fifo_level  <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
            drop_cnt    <= (word_done & ~push & (drop_cnt != 8'hFF)) ? drop_cnt + 8'd1 : drop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word_next;
    end
endmodule

// File: tb/tb_hwrandom_pool.sv
// tb_hwrandom_pool: scoreboard bench; a bit-level model predicts words, a monitor checks every pop.
module tb_hwrandom_pool;
    logic       clk = 0, reset = 1;
    logic [7:0] raw_in = '0;
    logic       debias_en = 0, out_ready = 0, health_clear = 0;
    logic [7:0] out_data, drop_cnt;
    logic       out_valid, health_fail;
    logic [4:0] fifo_level;

    int         tests = 0, fails = 0, pops = 0;
    logic [7:0] expq[$];
    logic [7:0] acc = '0, held;
    bit         model_on = 1, dbm = 0, ph = 0, pa = 0;
    int         bc = 0;

    hwrandom_pool dut (
        .clk(clk), .reset(reset), .raw_in(raw_in), .debias_en(debias_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .health_fail(health_fail),
        .health_clear(health_clear), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL scoreboard: got unexpected word %h, expected none", out_data);
            end else begin
                if (out_data !== expq[0]) begin
                    fails++;
                    $display("FAIL scoreboard: got %h, expected %h", out_data, expq[0]);
                end
                void'(expq.pop_front());
            end
            pops++;
        end
    end

    task automatic model_bit(input logic b);
        logic x;
        if (!model_on) return;
        x = b;
        if (dbm) begin
            if (!ph) begin
                pa = b;
                ph = 1;
                return;
            end
            ph = 0;
            if (pa == b) return;
            x = pa;
        end
        acc[bc] = x;
        bc++;
        if (bc == 8) begin
            expq.push_back(acc);
            bc = 0;
        end
    endtask

    task automatic cyc(input logic b);
        raw_in = {7'b0, b};
        model_bit(b);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) cyc(w[i]);
    endtask

    task automatic do_reset;
        reset = 1;
        raw_in = '0;
        health_clear = 0;
        out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        expq.delete();
        bc = 0;
        ph = 0;
        model_on = 1;
        pops = 0;
    endtask

    task automatic drain(input int want);
        for (int i = 0; i < 120 && !(pops >= want && expq.size() == 0 && fifo_level == 0); i++) cyc(i[0]);
    endtask

    task automatic test_reset;
        do_reset;
        tests++;
        if ({out_valid, out_data, fifo_level, health_fail, drop_cnt} !== '0) begin
            fails++;
            $display("FAIL reset: got v=%b d=%h lvl=%0d hf=%b drop=%0d, expected all zero",
                     out_valid, out_data, fifo_level, health_fail, drop_cnt);
        end
    endtask

    task automatic test_raw;
        logic [7:0] bits = 8'h4D;
        do_reset;
        for (int i = 0; i < 8; i++) cyc(bits[i]);
        cyc(0);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL raw_early: got valid=%b, expected 0", out_valid); end
        cyc(1);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h4D || fifo_level !== 5'd1) begin
            fails++;
            $display("FAIL raw_word: got v=%b d=%h lvl=%0d, expected v=1 d=4d lvl=1", out_valid, out_data, fifo_level);
        end
        out_ready = 1;
        send_word(8'h96);
        send_word(8'h3C);
        send_word(8'hE1);
        drain(4);
        tests++;
        if (pops < 4 || expq.size() != 0 || fifo_level !== 5'd0) begin
            fails++;
            $display("FAIL back_to_back: got pops=%0d pending=%0d lvl=%0d, expected pops>=4 pending=0 lvl=0",
                     pops, expq.size(), fifo_level);
        end
    endtask

    task automatic test_debias;
        logic [23:0] pairs = 24'b10_01_10_01_10_10_01_01_00_10_11_01;
        dbm = 1;
        debias_en = 1;
        do_reset;
        for (int i = 0; i < 12; i++) begin
            cyc(pairs[2*i]);
            cyc(pairs[2*i+1]);
        end
        repeat (4) cyc(1);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h4D || fifo_level !== 5'd1 || bc != 2) begin
            fails++;
            $display("FAIL debias_word: got v=%b d=%h lvl=%0d partial=%0d, expected v=1 d=4d lvl=1 partial=2",
                     out_valid, out_data, fifo_level, bc);
        end
        out_ready = 1;
        repeat (2) cyc(1);
        tests++;
        if (pops != 1 || fifo_level !== 5'd0) begin
            fails++;
            $display("FAIL debias_drain: got pops=%0d lvl=%0d, expected pops=1 lvl=0", pops, fifo_level);
        end
        dbm = 0;
        debias_en = 0;
    endtask

    task automatic test_full;
        logic [3:0] n;
        do_reset;
        for (int i = 0; i < 17; i++) begin
            n = i[3:0];
            send_word({~n, n});
        end
        cyc(0);
        cyc(1);
        tests++;
        if (fifo_level !== 5'd16 || out_valid !== 1'b1 || drop_cnt !== 8'd1) begin
            fails++;
            $display("FAIL full: got lvl=%0d v=%b drop=%0d, expected lvl=16 v=1 drop=1", fifo_level, out_valid, drop_cnt);
        end
        void'(expq.pop_back());
        held = out_data;
        cyc(0);
        tests++;
        if (out_data !== 8'hF0 || held !== 8'hF0) begin
            fails++;
            $display("FAIL full_hold: got %h then %h, expected f0 held", held, out_data);
        end
        out_ready = 1;
        drain(16);
        tests++;
        if (pops < 16 || expq.size() != 0 || fifo_level !== 5'd0) begin
            fails++;
            $display("FAIL full_drain: got pops=%0d pending=%0d lvl=%0d, expected pops>=16 pending=0 lvl=0",
                     pops, expq.size(), fifo_level);
        end
    endtask

    task automatic test_back_to_back_collision;
        logic [3:0] n;
        do_reset;
        for (int i = 0; i < 17; i++) begin
            n = i[3:0] ^ 4'h5;
            send_word({n, ~n});
        end
        cyc(0);
        tests++;
        if (fifo_level !== 5'd16 || drop_cnt !== 8'd0) begin
            fails++;
            $display("FAIL collide_pre: got lvl=%0d drop=%0d, expected lvl=16 drop=0", fifo_level, drop_cnt);
        end
        out_ready = 1;
        cyc(1);
        out_ready = 0;
        tests++;
        if (fifo_level !== 5'd16 || drop_cnt !== 8'd0 || pops != 1) begin
            fails++;
            $display("FAIL collide: got lvl=%0d drop=%0d pops=%0d, expected lvl=16 drop=0 pops=1",
                     fifo_level, drop_cnt, pops);
        end
        out_ready = 1;
        drain(17);
        tests++;
        if (pops < 17 || expq.size() != 0 || fifo_level !== 5'd0) begin
            fails++;
            $display("FAIL collide_drain: got pops=%0d pending=%0d lvl=%0d, expected pops>=17 pending=0 lvl=0",
                     pops, expq.size(), fifo_level);
        end
    endtask

    task automatic test_health;
        do_reset;
        out_ready = 1;
        repeat (32) cyc(0);
        model_on = 0;
        cyc(0);
        tests++;
        if (health_fail !== 1'b0) begin fails++; $display("FAIL health_early: got %b, expected 0", health_fail); end
        cyc(0);
        tests++;
        if (health_fail !== 1'b1) begin fails++; $display("FAIL health_trip: got %b, expected 1", health_fail); end
        repeat (6) cyc(0);
        tests++;
        if (health_fail !== 1'b1 || pops != 4 || expq.size() != 0 || fifo_level !== 5'd0) begin
            fails++;
            $display("FAIL health_inhibit: got hf=%b pops=%0d pending=%0d lvl=%0d, expected hf=1 pops=4 pending=0 lvl=0",
                     health_fail, pops, expq.size(), fifo_level);
        end
        model_on = 1;
        cyc(1);
        health_clear = 1;
        cyc(0);
        health_clear = 0;
        tests++;
        if (health_fail !== 1'b0) begin fails++; $display("FAIL health_clear: got %b, expected 0", health_fail); end
        send_word(8'hA5);
        drain(6);
        tests++;
        if (pops < 6 || expq.size() != 0 || health_fail !== 1'b0) begin
            fails++;
            $display("FAIL health_resume: got pops=%0d pending=%0d hf=%b, expected pops>=6 pending=0 hf=0",
                     pops, expq.size(), health_fail);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        send_word(8'h12);
        send_word(8'h34);
        send_word(8'h56);
        for (int i = 0; i < 7; i++) cyc(i[0]);
        tests++;
        if (fifo_level !== 5'd3) begin fails++; $display("FAIL mid_level: got %0d, expected 3", fifo_level); end
        #2;
        reset = 1;
        #1;
        tests++;
        if ({out_valid, out_data, fifo_level, health_fail, drop_cnt} !== '0) begin
            fails++;
            $display("FAIL mid_reset: got v=%b d=%h lvl=%0d hf=%b drop=%0d, expected all zero",
                     out_valid, out_data, fifo_level, health_fail, drop_cnt);
        end
        @(posedge clk);
        #1;
        do_reset;
        out_ready = 1;
        send_word(8'h5A);
        send_word(8'h81);
        drain(2);
        tests++;
        if (pops < 2 || expq.size() != 0) begin
            fails++;
            $display("FAIL mid_resume: got pops=%0d pending=%0d, expected pops>=2 pending=0", pops, expq.size());
        end
    endtask

    initial begin
        test_reset;
        test_raw;
        test_debias;
        test_full;
        test_back_to_back_collision;
        test_health;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hwrandom_pool.md
# hwrandom_pool

Parametrised entropy pool for the hardware RNG: it takes NUM_CHANNELS free-running ring-oscillator outputs and synchronises and XOR-combines them. It then optionally applies Von Neumann de-biasing, runs a continuous repetition-count health test, and packs fresh bits into WORD_BITS-wide words. Words are buffered in a FIFO behind a valid/ready port, which replaces the fixed 8-bit, unbuffered byte path that fed the UART transmitter directly.

## Interface
- NUM_CHANNELS, 8: number of raw entropy inputs (≥1)
- WORD_BITS, 8: output word width (≥2)
- FIFO_DEPTH, 16: word buffer depth (power of 2, ≥2)
- REP_LIMIT, 32: consecutive identical combined bits that trip the health test (≥2)

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- raw_in  in  NUM_CHANNELS  ring-oscillator outputs, asynchronous to clk
- debias_en  in  1  1 = Von Neumann de-bias, 0 = raw combined bits
- out_data  out  WORD_BITS  head-of-FIFO word, valid when out_valid=1
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered
- health_fail  out  1  sticky repetition-test failure
- health_clear  in  1  clears health_fail and the repetition counter
- drop_cnt  out  8  words lost to a full FIFO, saturates at 255

## Operation
- Synchroniser: each raw_in bit passes through 2 flops. The combined bit is cbit = XOR of the synchronised bits, evaluated every cycle.
- Repetition test:
  - rep_cnt counts consecutive cycles with cbit equal to the previous cbit.
  - It resets to 1 on a change of cbit.
  - When rep_cnt reaches REP_LIMIT, health_fail is set.
  - health_clear=1 clears health_fail and rep_cnt. If clear and trip happen in the same cycle, clear wins.
- While health_fail=1:
  - No bits enter the assembler and no words are pushed.
  - The partial word is discarded: bit_cnt is reset to 0.
- De-bias off: every cbit is a new bit.
- De-bias on:
  - A phase flop toggles every cycle.
  - Phase 0 stores cbit as the first bit of the pair (a).
  - Phase 1 compares a with the current cbit:
    - 10 emits 1.
    - 01 emits 0.
    - 00 and 11 emit nothing.
- Any change of debias_en, detected against a registered copy, resets the phase to 0 and bit_cnt to 0.
- Assembler:
  - Each new bit is written to word[bit_cnt], LSB first, and bit_cnt increments.
  - The bit that fills index WORD_BITS-1 completes the word. That word, including the new bit, is pushed the same cycle and bit_cnt returns to 0.
  - No bit is reused or wasted across words.
- FIFO: show-ahead; pop happens on out_valid & out_ready.
- Push rules:
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs the same cycle.
  - Otherwise the word is dropped and drop_cnt increments, saturating at 255.
  - A simultaneous push and pop leaves fifo_level unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is tracked separately so that full and empty are distinguishable.

## Timing
- Reset values:
  - out_valid=0, out_data=0, fifo_level=0
  - health_fail=0, drop_cnt=0
  - Phase, bit_cnt, rep_cnt and synchroniser flops are all 0.
- raw_in to cbit: 2 cycles of latency.
- De-bias on: a bit is emitted in the phase-1 cycle, so at most 1 bit per 2 cycles. De-bias off: 1 bit per cycle.
- Push to visibility: a word pushed at edge N appears at out_data/out_valid after edge N, visible in cycle N+1. There is no combinational bypass.
- Pop: out_data advances after the accepting edge, and fifo_level decrements on the same edge.
- out_data holds stable while out_valid=1 and out_ready=0.
- health_fail asserts on the edge where rep_cnt reaches REP_LIMIT. The assembler is inhibited from the following cycle.
- Reset asserted mid-word or mid-pair: everything clears immediately, with no partial word pushed. After deassertion, the first usable cbit arrives 2 cycles later.

## Test plan
1. Raw mode, WORD_BITS=8.
   - Stimulus: drive raw_in[0] so cbit = 1,0,1,1,0,0,1,0, other channels 0.
   - Required: out_data=0x4D is valid 1 cycle after the 8th bit, and fifo_level=1.
2. De-bias mode.
   - Stimulus: cbit pairs 10,11,01,00,10,10,01,01,10,01,10,01.
   - Required: emitted bits are 1,0,1,1,0,0,1,0,1,0. The first word is 0x4D.
3. Full FIFO, FIFO_DEPTH=16.
   - Stimulus: out_ready=0 while 17 words are generated.
   - Required: fifo_level=16, out_valid=1, drop_cnt=1.
   - Then set out_ready=1. Required: the 16 words drain in push order and fifo_level reaches 0.
4. Push/pop collision.
   - Stimulus: FIFO full, out_ready=1 on the cycle a word completes.
   - Required: the word is accepted, fifo_level stays 16, drop_cnt does not change.
5. Health test.
   - Stimulus: hold cbit=0 for 40 cycles with REP_LIMIT=32.
   - Required: health_fail=1 after the 32nd identical bit, and no further pushes.
   - Then pulse health_clear and toggle cbit. Required: health_fail=0 and words resume from bit_cnt=0.
6. Reset mid-word.
   - Stimulus: assert reset asynchronously after 5 bits, with 3 words buffered.
   - Required: all outputs return to reset values immediately. The next word is built from post-reset bits only.
